// File: rtl/pc_sequencer.sv
// Program-counter stage for the single-cycle MiniMIPS datapath.
// Holds the architectural PC, decides each cycle whether the datapath's
// NewCounter is committed, and provides run/pause/step/breakpoint control,
// out-of-range fault detection and a retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | after reset/restart; PC parked at RESET_PC, waiting for run
// RUN    | free-running; one instruction commits every edge
// PAUSED | halted by run=0 or a breakpoint; a step pulse commits exactly one
// FAULT  | committed PC left instruction memory; frozen until restart/reset

module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          IMEM_DEPTH = 256,
   parameter int          CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [31:0]      new_counter_i,
   input  logic             run_i,
   input  logic             step_i,
   input  logic             restart_i,
   input  logic             bkpt_en_i,
   input  logic [31:0]      bkpt_addr_i,
   output logic [31:0]      counter_o,
   output logic             commit_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] retired_o,
   output logic             bkpt_hit_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_FAULT  = 2'd3
   } state_e;

   // First PC value that lies outside instruction memory.
   localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH);

   state_e           state_q;
   logic [31:0]      counter_q;
   logic [CNT_W-1:0] retired_q;
   logic             bkpt_hit_q;

   logic             commit;
   logic             out_of_range;
   logic             bkpt_match;
   logic [CNT_W-1:0] retired_inc;

   // Retirement qualifier; also gates the datapath's RegWrite/MemWrite, so it
   // must stay combinational to suppress side effects in the same cycle.
   always_comb begin
      commit       = (state_q == ST_RUN) || ((state_q == ST_PAUSED) && step_i);
      out_of_range = (new_counter_i >= PC_LIMIT);
      bkpt_match   = bkpt_en_i && (new_counter_i == bkpt_addr_i);
      retired_inc  = retired_q + CNT_W'(1);
   end

   // Sequencer FSM with PC, retired count and breakpoint pulse registered
   // alongside it. Restart has top priority and leaves retired untouched.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         counter_q  <= RESET_PC;
         retired_q  <= '0;
         bkpt_hit_q <= 1'b0;
      end else begin
         bkpt_hit_q <= 1'b0;
         if (restart_i) begin
            state_q   <= ST_IDLE;
            counter_q <= RESET_PC;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (run_i) begin
                     state_q <= ST_RUN;
                  end
               end

               ST_RUN: begin
                  counter_q <= new_counter_i;
                  retired_q <= retired_inc;
                  if (out_of_range) begin
                     state_q <= ST_FAULT;
                  end else if (bkpt_match) begin
                     // PC lands on the breakpoint; that instruction is
                     // fetched but waits for run or step to execute.
                     state_q    <= ST_PAUSED;
                     bkpt_hit_q <= 1'b1;
                  end else if (!run_i) begin
                     state_q <= ST_PAUSED;
                  end
               end

               ST_PAUSED: begin
                  if (step_i) begin
                     // Breakpoint deliberately not checked here so the user
                     // can step off the breakpoint address.
                     counter_q <= new_counter_i;
                     retired_q <= retired_inc;
                     if (out_of_range) begin
                        state_q <= ST_FAULT;
                     end
                  end else if (run_i) begin
                     state_q <= ST_RUN;
                  end
               end

               ST_FAULT: begin
                  state_q <= ST_FAULT;
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign counter_o  = counter_q;
   assign commit_o   = commit;
   assign state_o    = state_q;
   assign retired_o  = retired_q;
   assign bkpt_hit_o = bkpt_hit_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. The datapath is modelled as PC+1 unless a
// branch target is forced through ovr_en/ovr_val.

module tb_pc_sequencer;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] new_counter;
   logic        run, step, restart, bkpt_en;
   logic [31:0] bkpt_addr;
   logic [31:0] counter;
   logic        commit;
   logic [1:0]  state;
   logic [31:0] retired;
   logic        bkpt_hit;

   logic        ovr_en;
   logic [31:0] ovr_val;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign new_counter = ovr_en ? ovr_val : counter + 32'd1;

   pc_sequencer #(
      .RESET_PC   (32'd0),
      .IMEM_DEPTH (DEPTH),
      .CNT_W      (32)
   ) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .new_counter_i (new_counter),
      .run_i         (run),
      .step_i        (step),
      .restart_i     (restart),
      .bkpt_en_i     (bkpt_en),
      .bkpt_addr_i   (bkpt_addr),
      .counter_o     (counter),
      .commit_o      (commit),
      .state_o       (state),
      .retired_o     (retired),
      .bkpt_hit_o    (bkpt_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] c, input logic [1:0] s,
                          input logic [31:0] r);
      chk({tag, ".counter"}, counter, c);
      chk({tag, ".state"}, {30'd0, state}, {30'd0, s});
      chk({tag, ".retired"}, retired, r);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; step = 1'b0; restart = 1'b0;
      bkpt_en = 1'b0; bkpt_addr = 32'd0; ovr_en = 1'b0; ovr_val = 32'd0;

      // Reset state
      #12;
      chk_all("reset", 32'd0, 2'd0, 32'd0);
      chk("reset.bkpt_hit", {31'd0, bkpt_hit}, 32'd0);
      chk("reset.commit", {31'd0, commit}, 32'd0);

      // Reset release and free-run
      rst_n = 1'b1; run = 1'b1;
      #1;
      chk("idle.state", {30'd0, state}, 32'd0);
      tick();
      chk_all("run.enter", 32'd0, 2'd1, 32'd0);
      chk("run.commit", {31'd0, commit}, 32'd1);
      tick(); chk("run.pc1", counter, 32'd1);
      tick(); chk("run.pc2", counter, 32'd2);
      tick(); chk_all("run.pc3", 32'd3, 2'd1, 32'd3);
      tick(); tick();
      chk("run.pc5", counter, 32'd5);

      // Pause: the instruction at 5 still commits
      run = 1'b0;
      tick();
      chk_all("pause.enter", 32'd6, 2'd2, 32'd6);
      chk("pause.commit", {31'd0, commit}, 32'd0);
      tick();
      chk_all("pause.hold", 32'd6, 2'd2, 32'd6);
      step = 1'b1;
      #1 chk("step.commit", {31'd0, commit}, 32'd1);
      tick();
      step = 1'b0;
      chk_all("step.one", 32'd7, 2'd2, 32'd7);
      tick();
      chk_all("step.nostep", 32'd7, 2'd2, 32'd7);

      // Restart back to IDLE, retired kept
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk_all("restart", 32'd0, 2'd0, 32'd7);

      // Breakpoint at 10
      bkpt_en = 1'b1; bkpt_addr = 32'd10; run = 1'b1;
      tick();
      chk_all("bk.run", 32'd0, 2'd1, 32'd7);
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk("bk.pc", counter, 32'(i));
         chk("bk.nohit", {31'd0, bkpt_hit}, 32'd0);
      end
      tick();
      run = 1'b0;
      chk_all("bk.hit", 32'd10, 2'd2, 32'd17);
      chk("bk.pulse", {31'd0, bkpt_hit}, 32'd1);
      tick();
      chk("bk.pulse_end", {31'd0, bkpt_hit}, 32'd0);
      chk_all("bk.hold", 32'd10, 2'd2, 32'd17);
      run = 1'b1;
      tick();
      chk_all("bk.resume", 32'd10, 2'd1, 32'd17);
      tick();
      chk_all("bk.off", 32'd11, 2'd1, 32'd18);

      // Range boundary and fault
      ovr_en = 1'b1; ovr_val = 32'(DEPTH - 1);
      tick();
      chk_all("rng.last", 32'(DEPTH - 1), 2'd1, 32'd19);
      ovr_val = 32'(DEPTH);
      tick();
      chk_all("fault.enter", 32'(DEPTH), 2'd3, 32'd20);
      chk("fault.commit", {31'd0, commit}, 32'd0);
      ovr_en = 1'b0; step = 1'b1;
      tick();
      step = 1'b0;
      chk_all("fault.hold", 32'(DEPTH), 2'd3, 32'd20);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk_all("fault.restart", 32'd0, 2'd0, 32'd20);

      // Priority: restart beats step in PAUSED
      tick(); tick();
      run = 1'b0;
      tick();
      chk_all("prio.paused", 32'd2, 2'd2, 32'd22);
      restart = 1'b1; step = 1'b1;
      tick();
      restart = 1'b0; step = 1'b0;
      chk_all("prio.restart", 32'd0, 2'd0, 32'd22);

      // Step in IDLE is ignored
      step = 1'b1;
      #1 chk("idle.commit", {31'd0, commit}, 32'd0);
      tick();
      step = 1'b0;
      chk_all("idle.step", 32'd0, 2'd0, 32'd22);

      // Fault reached by a step while paused
      run = 1'b1;
      tick();
      run = 1'b0;
      tick();
      chk_all("sf.paused", 32'd1, 2'd2, 32'd23);
      ovr_en = 1'b1; ovr_val = 32'd100; step = 1'b1;
      tick();
      step = 1'b0; ovr_en = 1'b0;
      chk_all("sf.fault", 32'd100, 2'd3, 32'd24);
      restart = 1'b1;
      tick();
      restart = 1'b0;

      // Async reset mid-run at counter 42
      run = 1'b1;
      tick();
      ovr_en = 1'b1; ovr_val = 32'd42;
      tick();
      ovr_en = 1'b0;
      chk_all("ar.pre", 32'd42, 2'd1, 32'd25);
      #3 rst_n = 1'b0;
      #1;
      chk_all("ar.now", 32'd0, 2'd0, 32'd0);
      chk("ar.commit", {31'd0, commit}, 32'd0);
      run = 1'b0;
      #10 rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
